// File: rtl/safety_arb_pkg.sv
// -----------------------------------------------------------------------------
// safety_arb_pkg
// Shared constants and types for the safety-island AXI4 read arbiter.
//   AXI_SIZE_64    : ARSIZE encoding for 8-byte beats
//   AXI_BURST_INCR : ARBURST encoding for INCR bursts
//   arb_state_e    : AR arbitration state (IDLE / LOCKED)
// -----------------------------------------------------------------------------
package safety_arb_pkg;

  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/safety_arb_order_fifo.sv
// -----------------------------------------------------------------------------
// safety_arb_order_fifo
// Records the requester index of every accepted AR burst so that R beats can
// be routed back in issue order.
// Parameters: DEPTH (power of 2, >= 2), WIDTH (index width)
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i, din_i  : enqueue an index (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   dout_o         : head entry
//   full_o/empty_o : occupancy flags
//   count_o        : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module safety_arb_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push is refused when full even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/safety_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// safety_axi_rd_arbiter
// Shares one 64-bit INCR AXI4 read master among N_REQ requesters. AR is
// round-robin arbitrated; R beats are routed in order using a FIFO of granted
// requester indices (no AXI IDs downstream).
// Optional macro: SAFETY_RD_ARB_TIMEOUT_EN builds a response watchdog that
//   sets timeout_o (sticky) after TIMEOUT_CYC cycles without an R handshake
//   while bursts are outstanding. Without the macro timeout_o is tied low.
// Ports:
//   req_ar*    : per-requester AR channel (requester k at slice k)
//   req_r*     : R data/resp/last broadcast, one-hot rvalid, per-requester rready
//   m_ar*/m_r* : master AXI read channels
//   outst_cnt_o   : bursts accepted downstream and not yet completed
//   err_unexp_r_o : sticky, R beat seen with no outstanding burst
//   timeout_o     : sticky watchdog flag
// -----------------------------------------------------------------------------
module safety_axi_rd_arbiter
  import safety_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MAX_OUTST   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [N_REQ*ADDR_W-1:0]     req_araddr_i,
  input  logic [N_REQ*8-1:0]          req_arlen_i,
  input  logic [N_REQ-1:0]            req_arvalid_i,
  output logic [N_REQ-1:0]            req_arready_o,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic [1:0]                  req_rresp_o,
  output logic                        req_rlast_o,
  output logic [N_REQ-1:0]            req_rvalid_o,
  input  logic [N_REQ-1:0]            req_rready_i,
  output logic [ADDR_W-1:0]           m_araddr_o,
  output logic [7:0]                  m_arlen_o,
  output logic [2:0]                  m_arsize_o,
  output logic [1:0]                  m_arburst_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic [DATA_W-1:0]           m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic                        m_rlast_i,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt_o,
  output logic                        err_unexp_r_o,
  output logic                        timeout_o
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, rr_q, rr_d;
  logic [IDX_W-1:0] pick, cand, cur_grant, head;
  logic             found, ar_push, fifo_full, fifo_empty, r_hs, pop;
  logic             err_unexp_q, err_unexp_d;

  // Round-robin: first valid requester at or after the pointer.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % N_REQ);
      if (!found && req_arvalid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // IDLE grants in the same cycle it sees a request, so AR valid/address are
  // combinational from IDLE; LOCKED holds the grant until the handshake.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cur_grant   = grant_q;
    m_arvalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          cur_grant   = pick;
          grant_d     = pick;
          m_arvalid_o = 1'b1;
          state_d     = LOCKED;
        end
      end
      LOCKED: m_arvalid_o = 1'b1;
    endcase
    if (m_arvalid_o && m_arready_i) begin
      rr_d    = IDX_W'((int'(cur_grant) + 1) % N_REQ);
      state_d = IDLE;
    end
  end

  assign ar_push     = m_arvalid_o && m_arready_i;
  assign m_araddr_o  = req_araddr_i[cur_grant*ADDR_W +: ADDR_W];
  assign m_arlen_o   = req_arlen_i[cur_grant*8 +: 8];
  assign m_arsize_o  = AXI_SIZE_64;
  assign m_arburst_o = AXI_BURST_INCR;

  always_comb begin
    req_arready_o = '0;
    if (ar_push) req_arready_o[cur_grant] = 1'b1;
  end

  // R path: route to FIFO head; with nothing outstanding, drain and flag.
  assign m_rready_o  = fifo_empty ? m_rvalid_i : req_rready_i[head];
  assign r_hs        = m_rvalid_i && m_rready_o;
  assign pop         = r_hs && m_rlast_i && !fifo_empty;
  assign req_rdata_o = m_rdata_i;
  assign req_rresp_o = m_rresp_i;
  assign req_rlast_o = m_rlast_i;

  always_comb begin
    req_rvalid_o = '0;
    if (!fifo_empty && m_rvalid_i) req_rvalid_o[head] = 1'b1;
  end

  assign err_unexp_d   = err_unexp_q || (fifo_empty && m_rvalid_i);
  assign err_unexp_r_o = err_unexp_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  safety_arb_order_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (ar_push),
    .din_i   (cur_grant),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outst_cnt_o)
  );

`ifdef SAFETY_RD_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_q, timeout_d;

  // Counter saturates at the limit; any R handshake restarts it.
  always_comb begin
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
    if (r_hs || (outst_cnt_o == '0)) begin
      tmr_d = '0;
    end else if (tmr_q != TMR_W'(TIMEOUT_CYC)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if (tmr_d == TMR_W'(TIMEOUT_CYC)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  // Always false; referencing TIMEOUT_CYC keeps the parameter in use.
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule
